// File: rtl/pio_arb_pkg.sv
// pio_bus_arbiter shared types.
// FSM states, one-hot grant codes and the timeout counter width.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int TO_W = 16;

endpackage

// File: rtl/pio_arb_timeout.sv
// Saturating wait counter for a granted strobe.
// Terminal count flags when the count equals TIMEOUT.
module pio_arb_timeout
    import pio_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TO_W-1:0] LP_TC = TO_W'(TIMEOUT);

    logic [TO_W-1:0] r_count;

    // Clear wins over count; hold at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == LP_TC);

endmodule

// File: rtl/pio_bus_arbiter.sv
// Two-master Wishbone classic arbiter in front of the PIO slave.
// Round-robin on contention, bus error on a hung strobe.
module pio_bus_arbiter
    import pio_arb_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 255,
    localparam int SEL_W   = DATA_W / 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    arb_state_t r_state;
    logic [1:0] r_grant;
    logic       r_last;

    logic w_req0;
    logic w_req1;
    logic w_own_cyc;
    logic w_own_stb;
    logic w_granted;
    logic w_tc;
    logic w_abort;
    logic w_to_clr;
    logic w_to_en;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;

    assign w_granted = (r_state == GNT0) | (r_state == GNT1);

    // Owner's cyc/stb; grant also names the owner while aborting.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        unique case (1'b1)
            r_grant[0]: begin
                w_own_cyc = m0_cyc_i;
                w_own_stb = m0_stb_i;
            end
            r_grant[1]: begin
                w_own_cyc = m1_cyc_i;
                w_own_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // An ack or a dropped cycle in the terminal cycle suppresses the error.
    assign w_abort = w_granted & w_own_cyc & w_own_stb & w_tc & ~s_ack_i;

    assign w_to_clr = ~w_granted | s_ack_i;
    assign w_to_en  = w_granted & w_own_stb & ~s_ack_i;

    pio_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n),
        .i_clr   (w_to_clr),
        .i_en    (w_to_en),
        .o_tc    (w_tc)
    );

    // Arbitration FSM with registered grant and round-robin history.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= IDLE;
            r_grant <= GNT_NONE;
            r_last  <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    unique case (1'b1)
                        (w_req0 & w_req1): begin
                            if (r_last) begin
                                r_state <= GNT0;
                                r_grant <= GNT_M0;
                                r_last  <= 1'b0;
                            end else begin
                                r_state <= GNT1;
                                r_grant <= GNT_M1;
                                r_last  <= 1'b1;
                            end
                        end
                        (w_req0 & ~w_req1): begin
                            r_state <= GNT0;
                            r_grant <= GNT_M0;
                        end
                        (w_req1 & ~w_req0): begin
                            r_state <= GNT1;
                            r_grant <= GNT_M1;
                        end
                        default: ;
                    endcase
                end
                GNT0, GNT1: begin
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                    end else if (w_abort) begin
                        r_state <= ABORT;
                    end
                end
                ABORT: begin
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

    assign grant_o   = r_grant;
    assign timeout_o = w_abort;

    // Route the owner to the slave and the slave response to the owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (r_state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = w_abort;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = w_abort;
            end
            default: ;
        endcase
    end

endmodule
